// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
//
// Definitions shared between the traffic signal controller and the
// country-road vehicle detector:
//   - RED / YELLOW / GREEN : one-hot RYG lamp codes as seen on the
//                            controller's country-road lamp bus
//   - det_state_t          : detector FSM state encoding
//   - lamp_is_legal()      : true for exactly one of the three lamp codes
//
// There are no ports; this file only declares types, constants and a helper.
// -----------------------------------------------------------------------------
package traffic_pkg;

  // Lamp bus is ordered {R, Y, G}.
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [1:0] {
    DET_IDLE    = 2'd0,  // no cars waiting, no request
    DET_REQ     = 2'd1,  // request raised, waiting for the country green
    DET_SERVE   = 2'd2,  // country green being served
    DET_HOLDOFF = 2'd3   // request withdrawn, waiting out the red gap
  } det_state_t;

  function automatic logic lamp_is_legal(input logic [2:0] lamp);
    return (lamp == RED) || (lamp == YELLOW) || (lamp == GREEN);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// -----------------------------------------------------------------------------
// sensor_debounce
//
// Brings the asynchronous inductive-loop sensor into the clk domain with a
// two-flop synchronizer, then filters it. The filtered output only changes
// once the synchronized value has differed from it for DEBOUNCE consecutive
// cycles; any shorter excursion is discarded.
//
// Parameters:
//   DEBOUNCE : consecutive differing cycles needed to toggle presence (>= 1)
//
// Ports:
//   clk      in  : clock, rising edge
//   clear_n  in  : synchronous active-low reset
//   sensor   in  : raw loop sensor, asynchronous, 1 = vehicle over loop
//   presence out : debounced sensor level
// -----------------------------------------------------------------------------
module sensor_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic clear_n,
  input  logic sensor,
  output logic presence
);

  // The counter only ever holds 0 .. DEBOUNCE-1: on the DEBOUNCE-th differing
  // cycle it is cleared instead of incremented.
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  // sync_reg[0] is the metastability-catching flop, sync_reg[1] is the
  // stable synchronized sample.
  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          presence_reg;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      sync_reg     <= 2'b00;
      cnt_reg      <= '0;
      presence_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], sensor};

      if (sync_reg[1] == presence_reg) begin
        // Agreement restarts the run; a glitch never accumulates.
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        presence_reg <= sync_reg[1];
        cnt_reg      <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign presence = presence_reg;

endmodule

// File: rtl/country_road_detector.sv
// -----------------------------------------------------------------------------
// country_road_detector
//
// Vehicle-detection front end for the country-road approach. Conditions the
// loop sensor (sensor_debounce), counts queued cars and drives the
// controller's `signal` request. The request closes the loop on the
// controller's country lamp: it is withdrawn once the queue is empty or a
// maximum green time has been served, and a new request is then held off
// until the lamp has been RED for HOLDOFF cycles.
//
// Car counting happens one clock after a debounced presence edge:
//   rising edge while the lamp is not GREEN -> car arrived, +1 (saturating)
//   falling edge while the lamp is GREEN    -> car left,    -1 (floor 0)
//   every other edge is ignored.
// The count is never touched by the FSM; cars still queued when a green
// ends simply re-request after the hold-off.
//
// Build option:
//   COUNTRY_LAMP_CHECK_EN : when defined, any lamp code other than RED,
//   YELLOW or GREEN sets the sticky `lamp_fault` flag, and the FSM is held
//   in IDLE (no request) from that edge until clear_n. Counting continues.
//   When undefined, `lamp_fault` is tied low.
//
// Parameters:
//   DEBOUNCE  : sensor debounce length in cycles (>= 1)
//   MAX_GREEN : max cycles of country GREEN served per request (>= 2)
//   HOLDOFF   : cycles of country RED required before re-requesting (>= 1)
//   CNT_W     : car counter width
//
// Ports:
//   clk          in  : clock, rising edge
//   clear_n      in  : synchronous active-low reset, dominates everything
//   sensor       in  : raw loop sensor, asynchronous
//   country_road in  : controller country lamp, one-hot {R,Y,G}
//   signal       out : car request to controller (decoded from state)
//   presence     out : debounced sensor
//   car_count    out : queued cars
//   lamp_fault   out : illegal lamp code seen (sticky)
// -----------------------------------------------------------------------------
module country_road_detector
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE  = 4,
  parameter int MAX_GREEN = 20,
  parameter int HOLDOFF   = 6,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             sensor,
  input  logic [2:0]       country_road,
  output logic             signal,
  output logic             presence,
  output logic [CNT_W-1:0] car_count,
  output logic             lamp_fault
);

  // Green timer holds 0 .. MAX_GREEN-1, gap timer holds 0 .. HOLDOFF-1.
  localparam int GW = (MAX_GREEN > 1) ? $clog2(MAX_GREEN) : 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [GW-1:0] GREEN_LAST = GW'(MAX_GREEN - 1);
  localparam logic [HW-1:0] GAP_LAST   = HW'(HOLDOFF - 1);

  logic lamp_green;
  logic lamp_red;
  logic force_idle;

  assign lamp_green = (country_road == GREEN);
  assign lamp_red   = (country_road == RED);

  // ---------------------------------------------------------------------------
  // Sensor conditioning
  // ---------------------------------------------------------------------------
  logic presence_db;

  sensor_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk      (clk),
    .clear_n  (clear_n),
    .sensor   (sensor),
    .presence (presence_db)
  );

  assign presence = presence_db;

  // ---------------------------------------------------------------------------
  // Car counter
  // ---------------------------------------------------------------------------
  logic             presence_prev_reg;
  logic [CNT_W-1:0] car_count_reg;
  logic             presence_rise;
  logic             presence_fall;

  assign presence_rise = presence_db & ~presence_prev_reg;
  assign presence_fall = ~presence_db & presence_prev_reg;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      presence_prev_reg <= 1'b0;
      car_count_reg     <= '0;
    end else begin
      presence_prev_reg <= presence_db;

      if (presence_rise && !lamp_green) begin
        if (!(&car_count_reg)) begin
          car_count_reg <= car_count_reg + 1'b1;
        end
      end else if (presence_fall && lamp_green) begin
        if (car_count_reg != '0) begin
          car_count_reg <= car_count_reg - 1'b1;
        end
      end
    end
  end

  assign car_count = car_count_reg;

  // ---------------------------------------------------------------------------
  // Lamp code checking
  // ---------------------------------------------------------------------------
`ifdef COUNTRY_LAMP_CHECK_EN
  logic lamp_fault_reg;
  logic lamp_bad;

  assign lamp_bad = !lamp_is_legal(country_road);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      lamp_fault_reg <= 1'b0;
    end else if (lamp_bad) begin
      lamp_fault_reg <= 1'b1;
    end
  end

  // The FSM is forced idle on the very edge that captures the bad code, so
  // the request drops together with lamp_fault rising.
  assign force_idle = lamp_fault_reg | lamp_bad;
  assign lamp_fault = lamp_fault_reg;
`else
  assign force_idle = 1'b0;
  assign lamp_fault = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  det_state_t    state_reg;
  logic [GW-1:0] green_tmr_reg;
  logic [HW-1:0] gap_tmr_reg;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_reg     <= DET_IDLE;
      green_tmr_reg <= '0;
      gap_tmr_reg   <= '0;
    end else if (force_idle) begin
      state_reg     <= DET_IDLE;
      green_tmr_reg <= '0;
      gap_tmr_reg   <= '0;
    end else begin
      case (state_reg)
        DET_IDLE: begin
          if (car_count_reg != '0) begin
            state_reg <= DET_REQ;
          end
        end

        DET_REQ: begin
          if (lamp_green) begin
            state_reg     <= DET_SERVE;
            green_tmr_reg <= '0;
          end
        end

        DET_SERVE: begin
          // Queue-empty exit wins over the max-green exit. A car still over
          // the loop keeps the green even if the counter reads zero.
          if ((car_count_reg == '0) && !presence_db) begin
            state_reg   <= DET_HOLDOFF;
            gap_tmr_reg <= '0;
          end else if (green_tmr_reg == GREEN_LAST) begin
            state_reg   <= DET_HOLDOFF;
            gap_tmr_reg <= '0;
          end else begin
            green_tmr_reg <= green_tmr_reg + 1'b1;
          end
        end

        DET_HOLDOFF: begin
          // Only an unbroken run of RED cycles counts toward the gap.
          if (lamp_red) begin
            if (gap_tmr_reg == GAP_LAST) begin
              state_reg <= DET_IDLE;
            end else begin
              gap_tmr_reg <= gap_tmr_reg + 1'b1;
            end
          end else begin
            gap_tmr_reg <= '0;
          end
        end

        default: begin
          state_reg <= DET_IDLE;
        end
      endcase
    end
  end

  assign signal = (state_reg == DET_REQ) || (state_reg == DET_SERVE);

endmodule
